// File: rtl/mem_arbiter_if.sv
// Signal bundle between the CPU fetch/data stages, the unified memory macro and
// the arbiter. The slave modport is the arbiter's view; master is everything around it.
interface mem_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_done, d_done, rdata, busy, mem_enable, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_done, d_done, rdata, busy, mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between instruction fetch and data access,
// latching the winning request and alternating grants under contention.
module mem_arbiter #(
    parameter int LATENCY = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LATENCY) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             last_owner;
    logic [15:0]      lat_addr;
    logic [15:0]      lat_wdata;
    logic [15:0]      rdata_q;
    logic             any_req;
    logic             grant_d;
    logic             mem_active;

    // D wins when it is alone, or when both ask and I held the previous grant.
    assign any_req = bus.i_req | bus.d_req;
    assign grant_d = bus.d_req & (~bus.i_req | (last_owner == OWNER_I));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= OWNER_I;
            last_owner <= OWNER_I;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= grant_d;
                        last_owner <= grant_d;
                        lat_addr   <= grant_d ? bus.d_addr : bus.i_addr;
                        lat_wdata  <= grant_d ? bus.d_wdata : 16'h0000;
                        cnt        <= CNT_W'(LATENCY);
                        state      <= (grant_d && bus.d_wr) ? WRITE : READ;
                    end
                end
                READ: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rdata_q <= bus.mem_rdata;
                        state   <= DONE;
                    end
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory bus is driven only while a transaction owns it, so reset clears it at once.
    assign mem_active     = (state == READ) || (state == WRITE);
    assign bus.mem_enable = mem_active;
    assign bus.mem_wr     = (state == WRITE);
    assign bus.mem_addr   = mem_active ? lat_addr : 16'h0000;
    assign bus.mem_wdata  = (state == WRITE) ? lat_wdata : 16'h0000;

    assign bus.i_done = (state == DONE) && (owner == OWNER_I);
    assign bus.d_done = (state == DONE) && (owner == OWNER_D);
    assign bus.busy   = (state != IDLE);
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a LATENCY=4 and a LATENCY=1 instance, a simple
// memory environment and a transaction-level scoreboard of memory contents.
module tb_mem_arbiter;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if b4 ();
    mem_arbiter_if b1 ();

    mem_arbiter #(.LATENCY(LAT)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mem_arbiter #(.LATENCY(1))   dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    always #5 clk = ~clk;

    // Memory environment: contents persist across arbiter resets; read data is
    // only valid in the LATENCY-th enabled cycle, garbage otherwise.
    logic         env_clr;
    logic [15:0]  mem_array [256];
    logic [255:0] written;
    int           en_cnt;

    function automatic logic [15:0] init_val(input logic [7:0] idx);
        if (idx == 8'h10) return 16'hBEEF;
        return {idx, ~idx} ^ 16'h3C5A;
    endfunction

    always @(posedge clk) begin
        if (env_clr) begin
            written <= '0;
        end else if (b4.mem_enable && b4.mem_wr) begin
            mem_array[b4.mem_addr[7:0]] <= b4.mem_wdata;
            written[b4.mem_addr[7:0]]   <= 1'b1;
        end
        if (b4.mem_enable && !b4.mem_wr) en_cnt <= en_cnt + 1;
        else                             en_cnt <= 0;
    end

    always_comb begin
        b4.mem_rdata = 16'hDEAD;
        if (b4.mem_enable && !b4.mem_wr && en_cnt == LAT - 1)
            b4.mem_rdata = written[b4.mem_addr[7:0]] ? mem_array[b4.mem_addr[7:0]]
                                                     : init_val(b4.mem_addr[7:0]);
        b1.mem_rdata = b1.mem_enable ? init_val(b1.mem_addr[7:0]) : 16'hDEAD;
    end

    // Scoreboard: expected memory contents and the value rdata should hold.
    logic [15:0] exp_mem [256];
    logic [15:0] exp_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b4.i_done, b4.d_done, b4.busy, b4.mem_enable, b4.mem_wr} !== 5'b0 ||
            b4.rdata !== 16'h0 || b4.mem_addr !== 16'h0 || b4.mem_wdata !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: ctrl=%b rdata=%h addr=%h wdata=%h, expected all zero",
                     {b4.i_done, b4.d_done, b4.busy, b4.mem_enable, b4.mem_wr},
                     b4.rdata, b4.mem_addr, b4.mem_wdata);
        end
        tick();
        tick();
        env_clr = 1'b0;
        rst_n   = 1'b1;
        tick();
        checks++;
        if (b4.busy !== 1'b0 || b1.busy !== 1'b0 || b1.rdata !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_idle: busy4=%b busy1=%b rdata1=%h, expected 0 0 0000",
                     b4.busy, b1.busy, b1.rdata);
        end
        exp_rdata = 16'h0000;
    endtask

    task automatic test_read();
        logic exp_en, exp_done, exp_busy;
        b4.i_req  = 1'b1;
        b4.i_addr = 16'h0010;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            exp_en   = (k <= LAT);
            exp_done = (k == LAT + 1);
            exp_busy = (k <= LAT + 1);
            checks++;
            if ({b4.mem_enable, b4.mem_wr, b4.i_done, b4.d_done, b4.busy} !==
                {exp_en, 1'b0, exp_done, 1'b0, exp_busy}) begin
                failures++;
                $display("[TB] FAIL read_ctrl k=%0d: en/wr/idone/ddone/busy=%b expected %b", k,
                         {b4.mem_enable, b4.mem_wr, b4.i_done, b4.d_done, b4.busy},
                         {exp_en, 1'b0, exp_done, 1'b0, exp_busy});
            end
            if (exp_en) begin
                checks++;
                if (b4.mem_addr !== 16'h0010) begin
                    failures++;
                    $display("[TB] FAIL read_addr k=%0d: got %h expected 0010", k, b4.mem_addr);
                end
            end
            if (k >= LAT + 1) begin
                checks++;
                if (b4.rdata !== 16'hBEEF) begin
                    failures++;
                    $display("[TB] FAIL read_rdata k=%0d: got %h expected beef", k, b4.rdata);
                end
            end
            if (k == LAT + 1) b4.i_req = 1'b0;
        end
        exp_rdata = 16'hBEEF;
    endtask

    task automatic test_write();
        b4.d_req   = 1'b1;
        b4.d_wr    = 1'b1;
        b4.d_addr  = 16'h0200;
        b4.d_wdata = 16'h1234;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({b4.mem_enable, b4.mem_wr, b4.d_done, b4.i_done, b4.busy} !==
                {k == 1, k == 1, k == 2, 1'b0, k <= 2}) begin
                failures++;
                $display("[TB] FAIL write_ctrl k=%0d: en/wr/ddone/idone/busy=%b expected %b", k,
                         {b4.mem_enable, b4.mem_wr, b4.d_done, b4.i_done, b4.busy},
                         {k == 1, k == 1, k == 2, 1'b0, k <= 2});
            end
            if (k == 1) begin
                checks++;
                if (b4.mem_addr !== 16'h0200 || b4.mem_wdata !== 16'h1234) begin
                    failures++;
                    $display("[TB] FAIL write_bus: addr=%h wdata=%h expected 0200 1234",
                             b4.mem_addr, b4.mem_wdata);
                end
            end
            checks++;
            if (b4.rdata !== exp_rdata) begin
                failures++;
                $display("[TB] FAIL write_rdata_hold k=%0d: got %h expected %h", k, b4.rdata, exp_rdata);
            end
            if (k == 2) begin
                b4.d_req = 1'b0;
                b4.d_wr  = 1'b0;
            end
        end
        exp_mem[8'h00] = 16'h1234;
    endtask

    task automatic test_withdraw();
        b4.i_req  = 1'b1;
        b4.i_addr = 16'h0040;
        for (int k = 1; k <= LAT + 5; k++) begin
            tick();
            if (k == 2) begin
                b4.i_addr = 16'h0123;
                b4.i_req  = 1'b0;
            end
            checks++;
            if ({b4.mem_enable, b4.i_done, b4.d_done, b4.busy} !==
                {k <= LAT, k == LAT + 1, 1'b0, k <= LAT + 1}) begin
                failures++;
                $display("[TB] FAIL withdraw_ctrl k=%0d: en/idone/ddone/busy=%b expected %b", k,
                         {b4.mem_enable, b4.i_done, b4.d_done, b4.busy},
                         {k <= LAT, k == LAT + 1, 1'b0, k <= LAT + 1});
            end
            if (k <= LAT) begin
                checks++;
                if (b4.mem_addr !== 16'h0040) begin
                    failures++;
                    $display("[TB] FAIL withdraw_addr k=%0d: got %h expected 0040", k, b4.mem_addr);
                end
            end
            if (k == LAT + 1) begin
                checks++;
                if (b4.rdata !== exp_mem[8'h40]) begin
                    failures++;
                    $display("[TB] FAIL withdraw_rdata: got %h expected %h", b4.rdata, exp_mem[8'h40]);
                end
            end
        end
        exp_rdata = exp_mem[8'h40];
    endtask

    task automatic test_random();
        logic        side, wr, obs, other;
        logic [15:0] addr, wdata;
        int          lat_exp, done_at;
        for (int n = 0; n < 40; n++) begin
            side    = 1'($urandom);
            wr      = side & 1'($urandom);
            addr    = {4'($urandom), 9'h000, 3'($urandom)};
            wdata   = 16'($urandom);
            lat_exp = wr ? 2 : LAT + 1;
            repeat ($urandom_range(0, 2)) tick();
            if (side) begin
                b4.d_req   = 1'b1;
                b4.d_wr    = wr;
                b4.d_addr  = addr;
                b4.d_wdata = wdata;
            end else begin
                b4.i_req  = 1'b1;
                b4.i_addr = addr;
            end
            done_at = 0;
            for (int k = 1; k <= 20 && done_at == 0; k++) begin
                tick();
                if (k == 1) begin
                    b4.i_addr  = 16'($urandom);
                    b4.d_addr  = 16'($urandom);
                    b4.d_wdata = 16'($urandom);
                    b4.d_wr    = 1'($urandom);
                end
                obs   = side ? b4.d_done : b4.i_done;
                other = side ? b4.i_done : b4.d_done;
                checks++;
                if (other !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL random_other_done n=%0d k=%0d: got 1 expected 0", n, k);
                end
                if (b4.mem_enable) begin
                    checks++;
                    if (b4.mem_addr !== addr || b4.mem_wr !== wr || (wr && b4.mem_wdata !== wdata)) begin
                        failures++;
                        $display("[TB] FAIL random_mem_bus n=%0d k=%0d: addr=%h wr=%b wdata=%h expected %h %b %h",
                                 n, k, b4.mem_addr, b4.mem_wr, b4.mem_wdata, addr, wr, wdata);
                    end
                end
                if (obs) done_at = k;
            end
            b4.i_req = 1'b0;
            b4.d_req = 1'b0;
            checks++;
            if (done_at != lat_exp) begin
                failures++;
                $display("[TB] FAIL random_latency n=%0d: done at cycle %0d expected %0d", n, done_at, lat_exp);
            end
            if (wr) exp_mem[addr[7:0]] = wdata;
            else    exp_rdata = exp_mem[addr[7:0]];
            checks++;
            if (b4.rdata !== exp_rdata) begin
                failures++;
                $display("[TB] FAIL random_rdata n=%0d: got %h expected %h", n, b4.rdata, exp_rdata);
            end
            tick();
            checks++;
            if (b4.busy !== 1'b0 || b4.i_done !== 1'b0 || b4.d_done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL random_idle n=%0d: busy/idone/ddone=%b expected 000",
                         n, {b4.busy, b4.i_done, b4.d_done});
            end
        end
        b4.d_wr = 1'b0;
    endtask

    task automatic test_contention();
        int          period, idx;
        logic        at_done, exp_i, exp_d;
        logic [15:0] exp_addr;
        period = LAT + 2;
        rst_n  = 1'b0;
        b4.i_req  = 1'b1;
        b4.i_addr = 16'h0031;
        b4.d_req  = 1'b1;
        b4.d_wr   = 1'b0;
        b4.d_addr = 16'h0005;
        tick();
        rst_n     = 1'b1;
        exp_rdata = 16'h0000;
        for (int k = 1; k < 4 * period; k++) begin
            tick();
            idx      = k / period;
            at_done  = (k % period) == period - 1;
            exp_d    = at_done && (idx % 2 == 0);
            exp_i    = at_done && (idx % 2 == 1);
            exp_addr = (idx % 2 == 0) ? 16'h0005 : 16'h0031;
            checks++;
            if ({b4.i_done, b4.d_done} !== {exp_i, exp_d}) begin
                failures++;
                $display("[TB] FAIL contention_done k=%0d: idone/ddone=%b expected %b",
                         k, {b4.i_done, b4.d_done}, {exp_i, exp_d});
            end
            if ((k % period) >= 1 && (k % period) <= LAT) begin
                checks++;
                if (b4.mem_enable !== 1'b1 || b4.mem_addr !== exp_addr) begin
                    failures++;
                    $display("[TB] FAIL contention_grant k=%0d: en=%b addr=%h expected 1 %h",
                             k, b4.mem_enable, b4.mem_addr, exp_addr);
                end
            end
            if (at_done) begin
                exp_rdata = exp_mem[exp_addr[7:0]];
                checks++;
                if (b4.rdata !== exp_rdata) begin
                    failures++;
                    $display("[TB] FAIL contention_rdata k=%0d: got %h expected %h", k, b4.rdata, exp_rdata);
                end
            end
        end
        b4.i_req = 1'b0;
        b4.d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_midread();
        logic [15:0] wdata;
        wdata     = 16'($urandom);
        b4.i_req  = 1'b1;
        b4.i_addr = 16'h0042;
        repeat (3) tick();
        checks++;
        if (b4.mem_enable !== 1'b1 || b4.mem_addr !== 16'h0042) begin
            failures++;
            $display("[TB] FAIL midread_active: en=%b addr=%h expected 1 0042", b4.mem_enable, b4.mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b4.i_done, b4.d_done, b4.busy, b4.mem_enable, b4.mem_wr} !== 5'b0 ||
            b4.rdata !== 16'h0 || b4.mem_addr !== 16'h0 || b4.mem_wdata !== 16'h0) begin
            failures++;
            $display("[TB] FAIL midread_async_reset: ctrl=%b rdata=%h addr=%h expected zeros",
                     {b4.i_done, b4.d_done, b4.busy, b4.mem_enable, b4.mem_wr}, b4.rdata, b4.mem_addr);
        end
        b4.i_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (b4.i_done !== 1'b0 || b4.busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midread_no_done k=%0d: idone=%b busy=%b expected 0 0", k, b4.i_done, b4.busy);
            end
        end
        rst_n      = 1'b1;
        exp_rdata  = 16'h0000;
        b4.i_req   = 1'b1;
        b4.d_req   = 1'b1;
        b4.d_wr    = 1'b1;
        b4.d_addr  = 16'h0006;
        b4.d_wdata = wdata;
        for (int k = 1; k <= LAT + 5; k++) begin
            tick();
            checks++;
            if ({b4.d_done, b4.i_done} !== {k == 2, k == LAT + 4}) begin
                failures++;
                $display("[TB] FAIL post_reset_done k=%0d: ddone/idone=%b expected %b",
                         k, {b4.d_done, b4.i_done}, {k == 2, k == LAT + 4});
            end
            if (k == 1) begin
                checks++;
                if (b4.mem_wr !== 1'b1 || b4.mem_addr !== 16'h0006 || b4.mem_wdata !== wdata) begin
                    failures++;
                    $display("[TB] FAIL post_reset_d_wins: wr=%b addr=%h wdata=%h expected 1 0006 %h",
                             b4.mem_wr, b4.mem_addr, b4.mem_wdata, wdata);
                end
            end
            if (k == 2) begin
                b4.d_req = 1'b0;
                b4.d_wr  = 1'b0;
                exp_mem[8'h06] = wdata;
            end
            if (k == LAT + 4) begin
                b4.i_req  = 1'b0;
                exp_rdata = exp_mem[8'h42];
                checks++;
                if (b4.rdata !== exp_rdata) begin
                    failures++;
                    $display("[TB] FAIL post_reset_loser_rdata: got %h expected %h", b4.rdata, exp_rdata);
                end
            end
        end
    endtask

    task automatic test_latency1();
        logic [15:0] addr;
        addr      = 16'h0077;
        b1.i_req  = 1'b1;
        b1.i_addr = addr;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if ({b1.mem_enable, b1.i_done, b1.d_done} !== {(k % 3) == 1, (k % 3) == 2, 1'b0}) begin
                failures++;
                $display("[TB] FAIL lat1_ctrl k=%0d: en/idone/ddone=%b expected %b",
                         k, {b1.mem_enable, b1.i_done, b1.d_done}, {(k % 3) == 1, (k % 3) == 2, 1'b0});
            end
            if ((k % 3) == 1) begin
                checks++;
                if (b1.mem_addr !== addr) begin
                    failures++;
                    $display("[TB] FAIL lat1_addr k=%0d: got %h expected %h", k, b1.mem_addr, addr);
                end
            end
            if ((k % 3) == 2) begin
                checks++;
                if (b1.rdata !== init_val(addr[7:0])) begin
                    failures++;
                    $display("[TB] FAIL lat1_rdata k=%0d: got %h expected %h", k, b1.rdata, init_val(addr[7:0]));
                end
                addr      = addr + 16'h0001;
                b1.i_addr = addr;
            end
        end
        b1.i_req = 1'b0;
        tick();
    endtask

    initial begin
        env_clr = 1'b1;
        rst_n   = 1'b0;
        b4.i_req = 1'b0; b4.i_addr = '0; b4.d_req = 1'b0; b4.d_wr = 1'b0; b4.d_addr = '0; b4.d_wdata = '0;
        b1.i_req = 1'b0; b1.i_addr = '0; b1.d_req = 1'b0; b1.d_wr = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(8'(i));
        exp_rdata = 16'h0000;

        test_reset();
        test_read();
        test_write();
        test_withdraw();
        test_random();
        test_contention();
        test_reset_midread();
        test_latency1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer that shares one multi-cycle unified memory between the instruction-fetch (I) and data (D) sides of the CPU. Each requester holds a request until it receives a one-cycle done pulse. The arbiter latches the winning request and drives the memory for a fixed latency. It returns read data in a register and alternates grants on contention so neither side starves. It sits between the fetch/memory pipeline stages and the memory macro, replacing separate instruction and data memories.

## Interface
- LATENCY, 4: memory read latency in cycles, ≥1; read data is valid on mem_rdata in the LATENCY-th cycle of enable.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_req  input  1  fetch request; read only; held until i_done.
- i_addr  input  16  fetch address; stable while i_req=1.
- d_req  input  1  data request; held until d_done.
- d_wr  input  1  1=write, 0=read; stable while d_req=1.
- d_addr  input  16  data address.
- d_wdata  input  16  write data.
- i_done  output  1  one-cycle pulse: I transaction complete, rdata valid.
- d_done  output  1  one-cycle pulse: D transaction complete (rdata valid if read).
- rdata  output  16  registered read data; holds until next read completes.
- busy  output  1  1 in any state other than IDLE.
- mem_enable  output  1  memory enable.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  16  memory address.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  memory read data.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: sample i_req/d_req.
  - If only one side is requesting, it wins.
  - If both are requesting, the side not granted last wins.
  - last_owner resets to I, so D wins the first contention.
  - At the clock edge, latch owner, addr, wr, and wdata; update last_owner. Go to WRITE if D with d_wr=1, else READ, and load cnt=LATENCY.
- READ: mem_enable=1, mem_wr=0, mem_addr=latched addr. cnt decrements each cycle. In the cycle with cnt==1, capture mem_rdata into rdata at the edge and go to DONE.
- WRITE: mem_enable=1, mem_wr=1, mem_addr/mem_wdata latched, for exactly one cycle; then go to DONE. Writes do not wait LATENCY.
- DONE: assert owner's done for one cycle; never both. No sampling in DONE; go to IDLE.
- The latched request is immutable once accepted. Changing or withdrawing req/addr/data mid-transaction has no effect, and done still pulses.
- The requester must drop req on the edge after its done pulse, or the same request is re-issued from IDLE.
- cnt width: clog2(LATENCY)+1; no wrap (loaded only in IDLE).
- mem_* outputs are 0 in IDLE and DONE; mem_addr/mem_wdata may be 0 there.

## Timing
- Reset (async, any state): state=IDLE, cnt=0, last_owner=I, rdata=0, i_done=d_done=0, busy=0, mem_enable=mem_wr=0, mem_addr=mem_wdata=0. An in-flight transaction is discarded with no done pulse.
- Read: req sampled in cycle 0, READ in cycles 1..LATENCY, done in cycle LATENCY+1, rdata valid from cycle LATENCY+1. Request-to-done = LATENCY+1 cycles.
- Write: req in cycle 0, WRITE in cycle 1, done in cycle 2.
- Minimum issue interval per requester: LATENCY+2 cycles (read) and 3 cycles (write). Minimum gap between transactions is one IDLE cycle.
- Both requests arriving in the same IDLE cycle: exactly one is granted. The loser is served in the next IDLE if it is still requesting.
- A request arriving during READ/WRITE/DONE waits and is sampled at the next IDLE.
- busy=1 from cycle 1 through the DONE cycle.

## Test plan
- Reset, then I read of 0x0010 with memory returning 0xBEEF, LATENCY=4 -> mem_enable high cycles 1-4, i_done pulses in cycle 5, rdata=0xBEEF, d_done stays 0.
- D write addr 0x0200, data 0x1234 -> mem_wr=1 for exactly cycle 1 with those values, d_done in cycle 2, rdata unchanged.
- i_req and d_req both asserted continuously from reset -> grants alternate D, I, D, I. Each done arrives LATENCY+2 cycles apart, with no two consecutive grants to the same side.
- Change i_addr and deassert i_req in cycle 2 of a READ -> mem_addr holds the original address, i_done still pulses in cycle 5, and no re-issue follows.
- rst_n low during cycle 3 of a READ -> all outputs 0 immediately (async). No done pulse. After release, a new D request completes normally and wins the first contention.
- LATENCY=1 build: read completes with done in cycle 2, and back-to-back reads from one requester occur every 3 cycles.
